// File: rtl/note_detector.sv
// note_detector: measures the period of a 1-bit tone input in clk cycles,
// classifies it against an 8-entry note table and reports a debounced note
// index with silence detection. Every output is taken from a flop.
module note_detector #(
  // Default table: octave-4 periods at a 25 MHz clk (DO RE MI FA SOL LA SI DO)
  parameter int unsigned N0      = 95556,
  parameter int unsigned N1      = 85131,
  parameter int unsigned N2      = 75843,
  parameter int unsigned N3      = 71586,
  parameter int unsigned N4      = 63776,
  parameter int unsigned N5      = 56818,
  parameter int unsigned N6      = 50619,
  parameter int unsigned N7      = 95556,
  parameter int unsigned TOL     = 64,
  parameter int unsigned STABLE  = 3,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned W       = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ch_in,
  output logic [2:0]   note,
  output logic         note_valid,
  output logic         note_strobe,
  output logic         silence,
  output logic [W-1:0] period
);

  localparam int unsigned HW = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
  localparam logic [W-1:0]  TOL_W   = W'(TOL);
  localparam logic [W-1:0]  TO_SAT  = W'(TIMEOUT);
  localparam logic [W-1:0]  TO_LAST = W'(TIMEOUT - 1);
  localparam logic [HW-1:0] STABLE_H = HW'(STABLE);

  typedef enum logic [1:0] {S_SILENT, S_ARMED, S_CAND, S_LOCK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  period_q, period_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [HW-1:0] hits_inc;
  logic [2:0]    cand_q, cand_d;
  logic [2:0]    note_q, note_d;
  logic          strobe_q, strobe_d;

  logic          rise;
  logic [W-1:0]  meas;
  logic [W-1:0]  nk, diff;
  logic          hit;
  logic [2:0]    hit_k;

  function automatic logic [W-1:0] nper(input logic [2:0] k);
    case (k)
      3'd0:    return W'(N0);
      3'd1:    return W'(N1);
      3'd2:    return W'(N2);
      3'd3:    return W'(N3);
      3'd4:    return W'(N4);
      3'd5:    return W'(N5);
      3'd6:    return W'(N6);
      default: return W'(N7);
    endcase
  endfunction

  // Synchronizer shift (two metastability flops plus one for edge history)
  always_comb begin
    sync_d = {sync_q[1:0], ch_in};
  end

  assign rise     = sync_q[1] & ~sync_q[2];
  assign meas     = cnt_q + 1'b1;
  assign hits_inc = hits_q + 1'b1;

  // Period counter: restarts on each edge, otherwise counts up and saturates
  always_comb begin
    if (rise)                cnt_d = '0;
    else if (cnt_q == TO_SAT) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // Classifier: scan high to low so the lowest matching index wins
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    nk    = '0;
    diff  = '0;
    for (int k = 7; k >= 0; k--) begin
      nk   = nper(3'(k));
      diff = (meas >= nk) ? (meas - nk) : (nk - meas);
      if (diff <= TOL_W) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_SILENT;
    else     state_q <= state_d;
  end

  // Next-state and datapath updates; only edges and timeouts move the FSM
  always_comb begin
    state_d  = state_q;
    hits_d   = hits_q;
    cand_d   = cand_q;
    note_d   = note_q;
    strobe_d = 1'b0;
    period_d = period_q;
    if (rise) begin
      // The first edge after silence only starts timing
      if (state_q != S_SILENT) period_d = meas;
      case (state_q)
        S_SILENT: begin
          state_d = S_ARMED;
          hits_d  = '0;
        end
        S_ARMED: begin
          if (hit) begin
            cand_d = hit_k;
            hits_d = HW'(1);
            if (STABLE == 1) begin
              state_d  = S_LOCK;
              note_d   = hit_k;
              strobe_d = 1'b1;
            end else begin
              state_d = S_CAND;
            end
          end
        end
        S_CAND: begin
          if (hit && hit_k == cand_q) begin
            hits_d = hits_inc;
            if (hits_inc == STABLE_H) begin
              state_d  = S_LOCK;
              note_d   = cand_q;
              strobe_d = 1'b1;
            end
          end else if (hit) begin
            cand_d = hit_k;
            hits_d = HW'(1);
          end else begin
            state_d = S_ARMED;
            hits_d  = '0;
          end
        end
        default: begin // S_LOCK
          if (hit && hit_k == note_q) begin
            state_d = S_LOCK;
          end else if (hit) begin
            cand_d = hit_k;
            hits_d = HW'(1);
            if (STABLE == 1) begin
              note_d   = hit_k;
              strobe_d = 1'b1;
            end else begin
              state_d = S_CAND;
            end
          end else begin
            state_d = S_ARMED;
            hits_d  = '0;
          end
        end
      endcase
    end else if (state_q != S_SILENT && cnt_q == TO_LAST) begin
      state_d = S_SILENT;
      hits_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      hits_q   <= '0;
      cand_q   <= '0;
      note_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      hits_q   <= hits_d;
      cand_q   <= cand_d;
      note_q   <= note_d;
      strobe_q <= strobe_d;
    end
  end

  // Outputs decoded straight from flops
  always_comb begin
    note        = note_q;
    note_valid  = (state_q == S_LOCK);
    note_strobe = strobe_q;
    silence     = (state_q == S_SILENT);
    period      = period_q;
  end

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: a run-length model of the note lock predicts every
// output each cycle; literal checks pin the model at key points.
module tb_note_detector;

  localparam int TOL = 2, STABLE = 3, TIMEOUT = 400, W = 20;
  localparam int NP [8] = '{100, 90, 80, 70, 60, 50, 40, 100};

  logic         clk = 1'b0;
  logic         rst;
  logic         ch_in;
  logic [2:0]   note;
  logic         note_valid, note_strobe, silence;
  logic [W-1:0] period;

  int tests = 0, fails = 0;
  int strobe_cnt = 0;
  int since_rise = 1000;

  note_detector #(
    .N0(100), .N1(90), .N2(80), .N3(70), .N4(60), .N5(50), .N6(40), .N7(100),
    .TOL(TOL), .STABLE(STABLE), .TIMEOUT(TIMEOUT), .W(W)
  ) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .note(note), .note_valid(note_valid),
    .note_strobe(note_strobe), .silence(silence), .period(period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {bit valid; bit strobe; bit silence; int note; int period;} exp_t;
  exp_t dl [3];

  int t, m_last, m_runk, m_runlen, m_note, m_period;
  bit m_prev, m_silent, m_valid, m_strobe;

  function automatic int classify(input int g);
    for (int k = 0; k < 8; k++)
      if (((g > NP[k]) ? g - NP[k] : NP[k] - g) <= TOL) return k;
    return -1;
  endfunction

  // Model works on ch_in rises as seen at posedge; outputs lag by two more clocks
  always @(posedge clk or posedge rst) begin
    int g, k;
    if (rst) begin
      t = 0; m_last = 0; m_runk = 0; m_runlen = 0; m_note = 0; m_period = 0;
      m_prev = 0; m_silent = 1; m_valid = 0; m_strobe = 0;
      for (int i = 0; i < 3; i++) dl[i] = '{0, 0, 1, 0, 0};
    end else begin
      t++;
      m_strobe = 0;
      if (ch_in && !m_prev) begin
        if (m_silent) begin
          m_silent = 0;
          m_runlen = 0;
        end else begin
          g = t - m_last;
          m_period = g;
          k = classify(g);
          if (k < 0) m_runlen = 0;
          else if (m_runlen > 0 && k == m_runk) m_runlen++;
          else begin m_runk = k; m_runlen = 1; end
          if (m_runlen == STABLE) begin m_note = m_runk; m_strobe = 1; end
        end
        m_last = t;
      end else if (!m_silent && t - m_last >= TIMEOUT) begin
        m_silent = 1;
        m_runlen = 0;
      end
      m_prev  = ch_in;
      m_valid = !m_silent && m_runlen >= STABLE;
      dl[2] = dl[1];
      dl[1] = dl[0];
      dl[0] = '{m_valid, m_strobe, m_silent, m_note, m_period};
    end
  end

  // Per-cycle compare against the model
  bit go = 0;
  always @(negedge clk) begin
    if (go) begin
      chk("valid",   int'(note_valid),  int'(dl[2].valid));
      chk("strobe",  int'(note_strobe), int'(dl[2].strobe));
      chk("silence", int'(silence),     int'(dl[2].silence));
      chk("note",    int'(note),        dl[2].note);
      chk("period",  int'(period),      dl[2].period);
      if (note_strobe) strobe_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    since_rise++;
  endtask

  // Next rising edge exactly g clocks after the previous one
  task automatic edge_at(input int g);
    while (since_rise < g / 2) tick();
    ch_in = 1'b0;
    while (since_rise < g) tick();
    ch_in = 1'b1;
    since_rise = 0;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    ch_in = 1'b0;
    repeat (2) @(negedge clk);
    go = 1;
    repeat (2) @(negedge clk);
    // reset values
    chk("rst_silence", int'(silence), 1);
    chk("rst_valid",   int'(note_valid), 0);
    chk("rst_strobe",  int'(note_strobe), 0);
    chk("rst_note",    int'(note), 0);
    chk("rst_period",  int'(period), 0);
    rst = 1'b0;
    repeat (3) tick();

    // 100-cycle tone: lock on 4th edge, tie with N7 resolves to 0
    edge_at(10);
    edge_at(100); edge_at(100); settle();
    chk("t2_prelock_valid", int'(note_valid), 0);
    chk("t2_silence", int'(silence), 0);
    edge_at(100); settle();
    chk("t2_strobes", strobe_cnt, 1);
    edge_at(100); edge_at(100); settle();
    chk("t2_note", int'(note), 0);
    chk("t2_valid", int'(note_valid), 1);
    chk("t2_period", int'(period), 100);
    chk("t2_strobes_end", strobe_cnt, 1);

    // jitter within TOL holds lock; switch to 90
    edge_at(101); edge_at(98); settle();
    chk("t3_hold_valid", int'(note_valid), 1);
    chk("t3_hold_period", int'(period), 98);
    edge_at(90); settle();
    chk("t3_drop_valid", int'(note_valid), 0);
    chk("t3_drop_note", int'(note), 0);
    edge_at(90); edge_at(90); settle();
    chk("t3_strobes", strobe_cnt, 2);
    chk("t3_note", int'(note), 1);
    chk("t3_valid", int'(note_valid), 1);

    // unmatched 150 period
    for (int i = 0; i < 3; i++) begin
      edge_at(150); settle();
      chk("t4_period", int'(period), 150);
      chk("t4_valid", int'(note_valid), 0);
      chk("t4_silence", int'(silence), 0);
    end
    chk("t4_strobes", strobe_cnt, 2);

    // tolerance edges around 50
    edge_at(50); edge_at(50); edge_at(50); settle();
    chk("tol_note", int'(note), 5);
    edge_at(52); edge_at(48); settle();
    chk("tol_in_valid", int'(note_valid), 1);
    edge_at(53); settle();
    chk("tol_out_valid", int'(note_valid), 0);
    chk("tol_out_period", int'(period), 53);

    // gap == TIMEOUT is still measured; gap == TIMEOUT+1 goes silent first
    edge_at(400); settle();
    chk("gap400_silence", int'(silence), 0);
    chk("gap400_period", int'(period), 400);
    edge_at(401); settle();
    chk("gap401_silence", int'(silence), 0);
    chk("gap401_period", int'(period), 400);
    edge_at(40); edge_at(40); edge_at(40); settle();
    chk("t40_note", int'(note), 6);
    chk("t40_valid", int'(note_valid), 1);

    // timeout exactly TIMEOUT clocks after the last edge is registered
    repeat (20) tick();
    ch_in = 1'b0;
    while (since_rise < 402) tick();
    chk("to_before_silence", int'(silence), 0);
    chk("to_before_valid", int'(note_valid), 1);
    tick();
    chk("to_silence", int'(silence), 1);
    chk("to_valid", int'(note_valid), 0);
    chk("to_note", int'(note), 6);

    // async reset mid-lock
    edge_at(10); edge_at(60); edge_at(60); edge_at(60); settle();
    chk("t6_note", int'(note), 4);
    @(posedge clk);
    #2 rst = 1'b1;
    ch_in = 1'b0;
    #1;
    chk("ar_silence", int'(silence), 1);
    chk("ar_valid", int'(note_valid), 0);
    chk("ar_note", int'(note), 0);
    chk("ar_period", int'(period), 0);
    chk("ar_strobe", int'(note_strobe), 0);
    repeat (3) tick();
    rst = 1'b0;
    since_rise = 1000;
    repeat (3) tick();
    edge_at(10); edge_at(70); edge_at(70); settle();
    chk("relock_early_valid", int'(note_valid), 0);
    edge_at(70); settle();
    chk("relock_valid", int'(note_valid), 1);
    chk("relock_note", int'(note), 3);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
